// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings: transfer types, response codes and the
// default-slave state encoding, plus small helpers used by the fabric.
package ahblite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_t;

  // Keeps only the lowest set bit so a multi-hot select still resolves deterministically.
  function automatic logic [NUM_PORTS-1:0] lowest_one_hot(input logic [NUM_PORTS-1:0] req);
    return req & (~req + {{(NUM_PORTS-1){1'b0}}, 1'b1});
  endfunction

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave for unmapped addresses: answers every active transfer that
// hits no enabled port with the two-cycle AHB ERROR response.
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic       unmapped,
  output logic       hreadyout,
  output logic       hresp
);

  def_state_t state_q;
  def_state_t state_d;
  logic       start_err;

  // An error sequence begins only when an active unmapped address phase is accepted.
  assign start_err = HREADY && is_active(HTRANS) && unmapped;

  // State register; reset drops any half-finished error response.
  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= DEF_IDLE;
    else        state_q <= state_d;
  end

  // Next state: ERR1 always advances, ERR2 may chain straight into another error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEF_IDLE: if (start_err) state_d = DEF_ERR1;
      DEF_ERR1: state_d = DEF_ERR2;
      DEF_ERR2: state_d = start_err ? DEF_ERR1 : DEF_IDLE;
      default:  state_d = DEF_IDLE;
    endcase
  end

  // Outputs: wait + ERROR in the first cycle, ready + ERROR in the second, OKAY otherwise.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      DEF_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      DEF_ERR2: begin
        hreadyout = 1'b1;
        hresp     = HRESP_ERROR;
      end
      default: begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer: latches the selected port at each accepted
// address phase and routes that port's data-phase response to the master.
// Addresses that hit no enabled port are answered by the built-in default slave.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [NUM_PORTS-1:0] PORT_EN = {Port3_en, Port2_en, Port1_en, Port0_en};

  logic [NUM_PORTS-1:0] hsel_en;
  logic [NUM_PORTS-1:0] sel_q;
  logic                 unmapped;
  logic                 def_hreadyout;
  logic                 def_hresp;

  // Absent ports are masked here so their selects look exactly like unmapped space.
  assign hsel_en  = {P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  assign unmapped = ~|hsel_en;

  // Data-phase owner: captured whenever the bus accepts an address phase, held during waits.
  always_ff @(posedge HCLK) begin
    if (HRESET)      sel_q <= '0;
    else if (HREADY) sel_q <= lowest_one_hot(hsel_en);
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .unmapped  (unmapped),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp)
  );

  // Response mux: an empty select means the default slave owns the data phase
  // (its idle outputs are the zero-wait OKAY), so no separate idle path is needed.
  always_comb begin
    HRDATA = '0;
    HREADY = def_hreadyout;
    HRESP  = def_hresp;
    case (sel_q)
      4'b0001: begin
        HRDATA = P0_HRDATA;
        HREADY = P0_HREADYOUT;
        HRESP  = P0_HRESP;
      end
      4'b0010: begin
        HRDATA = P1_HRDATA;
        HREADY = P1_HREADYOUT;
        HRESP  = P1_HRESP;
      end
      4'b0100: begin
        HRDATA = P2_HRDATA;
        HREADY = P2_HREADYOUT;
        HRESP  = P2_HRESP;
      end
      4'b1000: begin
        HRDATA = P3_HRDATA;
        HREADY = P3_HREADYOUT;
        HRESP  = P3_HRESP;
      end
      default: begin
        HRDATA = '0;
        HREADY = def_hreadyout;
        HRESP  = def_hresp;
      end
    endcase
  end

endmodule
